// File: rtl/cnt_rr_pkg.sv
// Shared direction constants and the counter next-value function.
// Saturating vs. wrapping behaviour is selected by CNT_RR_SAT_EN (counts up to 32 bits).
package cnt_rr_pkg;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // cnt_max is the all-ones value of the caller's counter width.
    function automatic logic [31:0] next_count(
        input logic [31:0] cnt,
        input logic [31:0] cnt_max,
        input logic        xfer,
        input logic        dir
    );
        logic [31:0] res;
        res = cnt;
        if (xfer) begin
            if (dir == DIR_INC) begin
`ifdef CNT_RR_SAT_EN
                res = (cnt == cnt_max) ? cnt : cnt + 32'd1;
`else
                res = (cnt == cnt_max) ? 32'd0 : cnt + 32'd1;
`endif
            end else begin
`ifdef CNT_RR_SAT_EN
                res = (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
`else
                res = (cnt == 32'd0) ? cnt_max : cnt - 32'd1;
`endif
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr, wrapping modulo N.
// ack advances ptr to one past the granted requester.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] ptr_next;
    int              idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        idx      = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % int'(N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                ptr_next = PtrW'((idx + 1) % int'(N));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ack) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/cnt_rr_sched.sv
// Shared up/down counter driven by N round-robin-arbitrated requesters, with registered
// threshold compare. Define CNT_RR_SAT_EN for a saturating counter (wraps otherwise).
module cnt_rr_sched #(
    parameter int unsigned W = 10,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] dir,
    input  logic         clr,
    input  logic [W-1:0] thresh,
    output logic [N-1:0] gnt,
    output logic [W-1:0] cnt_o,
    output logic         ge_o
);

    import cnt_rr_pkg::*;

    localparam logic [W-1:0] CntMax = '1;

    logic [N-1:0] arb_req;
    logic         xfer;
    logic         xfer_dir;
    logic [W-1:0] cnt_next;
    logic [W-1:0] thresh_d1;

    // Masking requests makes gnt zero under rst/clr and keeps ptr from moving.
    assign arb_req = (rst || clr) ? '0 : req;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .clk(clk),
        .rst(rst),
        .req(arb_req),
        .ack(xfer),
        .gnt(gnt)
    );

    assign xfer     = |gnt;
    assign xfer_dir = |(gnt & dir);

    always_comb begin
        cnt_next = W'(next_count(32'(cnt_o), 32'(CntMax), xfer, xfer_dir));
        if (clr) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_o     <= '0;
            ge_o      <= 1'b0;
            thresh_d1 <= '0;
        end else begin
            cnt_o     <= cnt_next;
            ge_o      <= (cnt_next >= thresh_d1);
            thresh_d1 <= thresh;
        end
    end

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Directed self-checking bench for cnt_rr_sched (W=10, N=4); follows CNT_RR_SAT_EN.
module tb_cnt_rr_sched;

    localparam int unsigned W = 10;
    localparam int unsigned N = 4;
`ifdef CNT_RR_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] dir;
    logic         clr;
    logic [W-1:0] thresh;
    logic [N-1:0] gnt;
    logic [W-1:0] cnt_o;
    logic         ge_o;

    int n_checks = 0;
    int n_errs   = 0;

    cnt_rr_sched #(
        .W(W),
        .N(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .dir(dir),
        .clr(clr),
        .thresh(thresh),
        .gnt(gnt),
        .cnt_o(cnt_o),
        .ge_o(ge_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one request cycle, check the combinational grant, then take the edge.
    task automatic xfer_cycle(input string tag, input logic [N-1:0] r, input logic [N-1:0] d,
                              input logic [N-1:0] exp_gnt);
        req = r;
        dir = d;
        #1;
        check(tag, 32'(gnt), 32'(exp_gnt));
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b1111;
        dir    = 4'b1111;
        clr    = 1'b0;
        thresh = 10'd3;
        step();
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        step();
        check("rst_cnt", 32'(cnt_o), 32'd0);
        check("rst_ge", 32'(ge_o), 32'd0);

        // Count up 1..5 against threshold 3 (thresh_d1 loaded on the idle edge).
        rst = 1'b0;
        req = '0;
        step();
        for (int i = 1; i <= 5; i++) begin
            xfer_cycle($sformatf("inc_gnt%0d", i), 4'b0001, 4'b0001, 4'b0001);
            check($sformatf("inc_cnt%0d", i), 32'(cnt_o), 32'(i));
            check($sformatf("inc_ge%0d", i), 32'(ge_o), (i >= 3) ? 32'd1 : 32'd0);
        end

        // Full rotation from ptr=0.
        do_reset();
        xfer_cycle("rot_gnt0", 4'b1111, 4'b1111, 4'b0001);
        xfer_cycle("rot_gnt1", 4'b1111, 4'b1111, 4'b0010);
        xfer_cycle("rot_gnt2", 4'b1111, 4'b1111, 4'b0100);
        xfer_cycle("rot_gnt3", 4'b1111, 4'b1111, 4'b1000);
        xfer_cycle("rot_gnt4", 4'b1111, 4'b1111, 4'b0001);
        check("rot_cnt", 32'(cnt_o), 32'd5);

        // Reach cnt=10 via requester 3, which leaves ptr at 0.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            xfer_cycle("pre_gnt", 4'b1000, 4'b1000, 4'b1000);
        end
        check("pre_cnt", 32'(cnt_o), 32'd10);
        xfer_cycle("alt_gnt0", 4'b0101, 4'b0001, 4'b0001);
        check("alt_cnt0", 32'(cnt_o), 32'd11);
        xfer_cycle("alt_gnt1", 4'b0101, 4'b0001, 4'b0100);
        check("alt_cnt1", 32'(cnt_o), 32'd10);
        xfer_cycle("alt_gnt2", 4'b0101, 4'b0001, 4'b0001);
        check("alt_cnt2", 32'(cnt_o), 32'd11);
        xfer_cycle("alt_gnt3", 4'b0101, 4'b0001, 4'b0100);
        check("alt_cnt3", 32'(cnt_o), 32'd10);

        // Underflow at 0.
        do_reset();
        step();
        xfer_cycle("dec0_gnt", 4'b0001, 4'b0000, 4'b0001);
        check("dec0_cnt", 32'(cnt_o), Sat ? 32'd0 : 32'd1023);
        check("dec0_ge", 32'(ge_o), Sat ? 32'd0 : 32'd1);

        // Overflow at 1023.
        do_reset();
        req = 4'b0001;
        dir = 4'b0001;
        for (int i = 0; i < 1023; i++) begin
            step();
        end
        check("top_cnt", 32'(cnt_o), 32'd1023);
        check("top_ge", 32'(ge_o), 32'd1);
        xfer_cycle("ovf_gnt", 4'b0001, 4'b0001, 4'b0001);
        check("ovf_cnt", 32'(cnt_o), Sat ? 32'd1023 : 32'd0);

        // Clear with a request pending: no grant, count zeroed, ptr stays at 1.
        clr = 1'b1;
        xfer_cycle("clr_gnt", 4'b0010, 4'b0010, 4'b0000);
        check("clr_cnt", 32'(cnt_o), 32'd0);
        check("clr_ge", 32'(ge_o), 32'd0);
        clr = 1'b0;
        xfer_cycle("postclr_gnt0", 4'b1111, 4'b1111, 4'b0010);
        check("postclr_cnt", 32'(cnt_o), 32'd1);
        xfer_cycle("postclr_gnt1", 4'b1111, 4'b1111, 4'b0100);

        // Reset mid-stream with all requests high.
        rst = 1'b1;
        xfer_cycle("midrst_gnt", 4'b1111, 4'b1111, 4'b0000);
        check("midrst_cnt", 32'(cnt_o), 32'd0);
        check("midrst_ge", 32'(ge_o), 32'd0);
        rst = 1'b0;
        xfer_cycle("afterrst_gnt", 4'b1111, 4'b1111, 4'b0001);
        check("afterrst_cnt", 32'(cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
